to_mem_request_scheduler: RTL and testbench

- Shares the single cache-to-memory channel among per-bank miss and writeback requesters.
- Selects one valid requester: critical requesters first, then round-robin among the rest.
- Registers the selected packet and holds it stable until memory acknowledges it.
- Sits between the cache banks' miss/writeback outputs and the unified cache's to-memory packet port.

---
 rtl/to_mem_request_scheduler_pkg.sv | 18 +
 rtl/rr_priority_picker.sv | 30 +++
 rtl/to_mem_request_scheduler.sv | 140 ++++++++++++++
 tb/tb_to_mem_request_scheduler.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/to_mem_request_scheduler_pkg.sv
// Shared constants and FSM state type for the cache-to-memory request scheduler.
package to_mem_request_scheduler_pkg;

  localparam int DEFAULT_PACKET_WIDTH  = 16;
  localparam int DEFAULT_VALID_POS     = 0;
  localparam int DEFAULT_AGE_THRESHOLD = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } sched_state_t;

  // Index width that stays legal (>= 1 bit) for a single requester.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set mask bit at or above the pointer, wrapping.
module rr_priority_picker #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     candidate_mask,
    input  logic [IDX_W-1:0] pointer,
    output logic [N-1:0]     winner_onehot,
    output logic [IDX_W-1:0] winner_idx,
    output logic             any_valid
);

    always_comb begin
        int unsigned pos;
        pos           = 0;
        winner_onehot = '0;
        winner_idx    = '0;
        any_valid     = 1'b0;
        for (int unsigned off = 0; off < N; off++) begin
            pos = 32'(pointer) + off;
            if (pos >= N) pos -= N;
            if (!any_valid && candidate_mask[pos[IDX_W-1:0]]) begin
                any_valid                        = 1'b1;
                winner_onehot[pos[IDX_W-1:0]]    = 1'b1;
                winner_idx                       = pos[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/to_mem_request_scheduler.sv
// Arbitrates per-bank miss/writeback requesters onto the single to-memory channel.
// Optional aging promotion: define TO_MEM_SCHEDULER_AGING_EN.
module to_mem_request_scheduler
    import to_mem_request_scheduler_pkg::*;
#(
    parameter int NUM_REQUEST   = 4,
    parameter int PACKET_WIDTH  = DEFAULT_PACKET_WIDTH,
    parameter int VALID_POS     = DEFAULT_VALID_POS,
    parameter int AGE_THRESHOLD = DEFAULT_AGE_THRESHOLD
) (
    input  logic                                clk_in,
    input  logic                                reset_in,
    input  logic [NUM_REQUEST*PACKET_WIDTH-1:0] request_flatted_in,
    input  logic [NUM_REQUEST-1:0]              request_valid_flatted_in,
    input  logic [NUM_REQUEST-1:0]              request_critical_flatted_in,
    output logic [NUM_REQUEST-1:0]              issue_ack_out,
    output logic [PACKET_WIDTH-1:0]             request_out,
    output logic                                request_valid_out,
    output logic [id_width(NUM_REQUEST)-1:0]    grant_id_out,
    input  logic                                issue_ack_in
);

    localparam int ID_W = id_width(NUM_REQUEST);

    if (AGE_THRESHOLD < 1) begin : g_bad_age_threshold
        $error("AGE_THRESHOLD must be at least 1");
    end

    sched_state_t            state_q, state_d;
    logic [ID_W-1:0]         ptr_q, ptr_d;
    logic [PACKET_WIDTH-1:0] req_d;
    logic                    vld_d;
    logic [ID_W-1:0]         gid_d;
    logic [NUM_REQUEST-1:0]  ack_d;

    logic [PACKET_WIDTH-1:0] packet [NUM_REQUEST];
    logic [NUM_REQUEST-1:0]  aged;
    logic [NUM_REQUEST-1:0]  urgent;
    logic [NUM_REQUEST-1:0]  candidates;
    logic [NUM_REQUEST-1:0]  win_onehot;
    logic [ID_W-1:0]         win_idx;
    logic                    win_any;

    for (genvar i = 0; i < NUM_REQUEST; i++) begin : g_unpack
        assign packet[i] = request_flatted_in[i*PACKET_WIDTH +: PACKET_WIDTH];
    end

`ifdef TO_MEM_SCHEDULER_AGING_EN
    localparam int AGE_W = $clog2(AGE_THRESHOLD) + 1;

    logic [AGE_W-1:0] age_q [NUM_REQUEST];

    always_ff @(posedge clk_in) begin
        for (int unsigned i = 0; i < NUM_REQUEST; i++) begin
            if (reset_in || !request_valid_flatted_in[i] || ack_d[i]) begin
                age_q[i] <= '0;
            end else if (age_q[i] != '1) begin
                age_q[i] <= age_q[i] + AGE_W'(1);
            end
        end
    end

    always_comb begin
        aged = '0;
        for (int unsigned i = 0; i < NUM_REQUEST; i++) begin
            aged[i] = (age_q[i] >= AGE_W'(AGE_THRESHOLD));
        end
    end
`else
    assign aged = '0;
`endif

    // Critical (or aged) requesters pre-empt the plain round-robin set.
    assign urgent     = request_valid_flatted_in & (request_critical_flatted_in | aged);
    assign candidates = (|urgent) ? urgent : request_valid_flatted_in;

    rr_priority_picker #(
        .N     (NUM_REQUEST),
        .IDX_W (ID_W)
    ) u_picker (
        .candidate_mask (candidates),
        .pointer        (ptr_q),
        .winner_onehot  (win_onehot),
        .winner_idx     (win_idx),
        .any_valid      (win_any)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        req_d   = request_out;
        vld_d   = request_valid_out;
        gid_d   = grant_id_out;
        ack_d   = '0;
        unique case (state_q)
            IDLE: begin
                if (win_any) begin
                    req_d   = packet[win_idx];
                    gid_d   = win_idx;
                    vld_d   = 1'b1;
                    ack_d   = win_onehot;
                    ptr_d   = (win_idx == ID_W'(NUM_REQUEST - 1)) ? '0 : win_idx + ID_W'(1);
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (issue_ack_in) begin
                    req_d   = '0;
                    vld_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q           <= IDLE;
            ptr_q             <= '0;
            request_out       <= '0;
            request_valid_out <= 1'b0;
            grant_id_out      <= '0;
            issue_ack_out     <= '0;
        end else begin
            state_q           <= state_d;
            ptr_q             <= ptr_d;
            request_out       <= req_d;
            request_valid_out <= vld_d;
            grant_id_out      <= gid_d;
            issue_ack_out     <= ack_d;
        end
    end

    a_valid_matches_packet: assert property (
        @(posedge clk_in) disable iff (reset_in)
        request_valid_out == request_out[VALID_POS]
    );

endmodule

// File: tb/tb_to_mem_request_scheduler.sv
// Self-checking bench: directed scenarios plus random traffic against a cycle-level reference model.
module tb_to_mem_request_scheduler;
    import to_mem_request_scheduler_pkg::*;

    localparam int N     = 4;
    localparam int PW    = DEFAULT_PACKET_WIDTH;
    localparam int VP    = DEFAULT_VALID_POS;
    localparam int AGE_T = DEFAULT_AGE_THRESHOLD;

    logic          clk_in = 1'b0;
    logic          reset_in = 1'b1;
    logic [N*PW-1:0] request_flatted_in;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_crit;
    logic [N-1:0]  issue_ack_out;
    logic [PW-1:0] request_out;
    logic          request_valid_out;
    logic [1:0]    grant_id_out;
    logic          issue_ack_in;
    logic [PW-1:0] pkt [N];

    to_mem_request_scheduler #(
        .NUM_REQUEST  (N),
        .PACKET_WIDTH (PW),
        .VALID_POS    (VP)
    ) dut (
        .clk_in                      (clk_in),
        .reset_in                    (reset_in),
        .request_flatted_in          (request_flatted_in),
        .request_valid_flatted_in    (req_valid),
        .request_critical_flatted_in (req_crit),
        .issue_ack_out               (issue_ack_out),
        .request_out                 (request_out),
        .request_valid_out           (request_valid_out),
        .grant_id_out                (grant_id_out),
        .issue_ack_in                (issue_ack_in)
    );

    always #5 clk_in = ~clk_in;

    always_comb begin
        request_flatted_in = '0;
        for (int i = 0; i < N; i++) request_flatted_in[i*PW +: PW] = pkt[i];
    end

    int total = 0;
    int bad   = 0;

    // Reference model: "holding" is just whether a packet is outstanding.
    logic [PW-1:0] m_pkt;
    logic          m_vld;
    int            m_gid;
    int            m_ptr;
    logic [N-1:0]  m_ack;
    int            m_age [N];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] rand_pkt();
        logic [PW-1:0] p;
        p     = PW'({$urandom, $urandom});
        p[VP] = 1'b1;
        return p;
    endfunction

    function automatic bit is_aged(input int i);
`ifdef TO_MEM_SCHEDULER_AGING_EN
        return m_age[i] >= AGE_T;
`else
        return (i < 0);
`endif
    endfunction

    task automatic model_update();
        int g;
        logic [N-1:0] urgent;
        logic [N-1:0] cand;
        if (reset_in) begin
            m_pkt = '0; m_vld = 1'b0; m_gid = 0; m_ptr = 0; m_ack = '0;
            for (int i = 0; i < N; i++) m_age[i] = 0;
            return;
        end
        g      = -1;
        m_ack  = '0;
        urgent = '0;
        for (int i = 0; i < N; i++)
            if (req_valid[i] && (req_crit[i] || is_aged(i))) urgent[i] = 1'b1;
        cand = (urgent != '0) ? urgent : req_valid;
        if (!m_vld) begin
            for (int k = 0; k < N && g < 0; k++)
                if (cand[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            if (g >= 0) begin
                m_pkt    = pkt[g];
                m_gid    = g;
                m_vld    = 1'b1;
                m_ack[g] = 1'b1;
                m_ptr    = (g + 1) % N;
            end
        end else if (issue_ack_in) begin
            m_pkt = '0;
            m_vld = 1'b0;
        end
        for (int i = 0; i < N; i++)
            m_age[i] = (req_valid[i] && i != g) ? m_age[i] + 1 : 0;
    endtask

    task automatic step();
        @(posedge clk_in);
        model_update();
        #1;
        check("pkt", 64'(request_out), 64'(m_pkt));
        check("vld", 64'(request_valid_out), 64'(m_vld));
        check("gid", 64'(grant_id_out), 64'(m_gid));
        check("ack", 64'(issue_ack_out), 64'(m_ack));
    endtask

    task automatic reset_dut();
        reset_in = 1'b1;
        step();
        reset_in = 1'b0;
    endtask

    task automatic randomize_inputs();
        req_valid = N'($urandom);
        req_crit  = N'($urandom) & N'($urandom);
        for (int i = 0; i < N; i++) pkt[i] = rand_pkt();
    endtask

    int exp_rr   [5] = '{0, 1, 2, 3, 0};
    int exp_crit [4] = '{3, 0, 1, 2};

    initial begin
        logic [PW-1:0] a5;
        logic [PW-1:0] held;
        int n;

        req_valid    = '0;
        req_crit     = '0;
        issue_ack_in = 1'b0;
        for (int i = 0; i < N; i++) pkt[i] = rand_pkt();

        reset_dut();
        check("rst_pkt", 64'(request_out), 64'd0);
        check("rst_vld", 64'(request_valid_out), 64'd0);
        check("rst_gid", 64'(grant_id_out), 64'd0);
        check("rst_ack", 64'(issue_ack_out), 64'd0);

        // Single request from requester 2
        a5       = '0;
        a5[7:0]  = 8'hA5;
        a5[VP]   = 1'b1;
        pkt[2]   = a5;
        req_valid = 4'b0100;
        step();
        check("single_pkt", 64'(request_out), 64'(a5));
        check("single_gid", 64'(grant_id_out), 64'd2);
        check("single_ack", 64'(issue_ack_out), 64'b0100);
        req_valid = '0;
        step();
        check("single_ack_once", 64'(issue_ack_out), 64'd0);
        step();
        step();
        check("single_still_held", 64'(request_valid_out), 64'd1);
        issue_ack_in = 1'b1;
        step();
        issue_ack_in = 1'b0;
        check("single_release", 64'(request_valid_out), 64'd0);

        // Round-robin with immediate memory acknowledge
        reset_dut();
        req_valid    = 4'b1111;
        req_crit     = '0;
        issue_ack_in = 1'b1;
        n = 0;
        for (int c = 0; c < 30 && n < 5; c++) begin
            step();
            if (issue_ack_out != '0) begin
                check("rr_order", 64'(grant_id_out), 64'(exp_rr[n]));
                n++;
            end
        end
        check("rr_grants", 64'(n), 64'd5);

        // Critical requester first, then the rest; each drops after its grant
        reset_dut();
        req_valid = 4'b1111;
        req_crit  = 4'b1000;
        n = 0;
        for (int c = 0; c < 30 && n < 4; c++) begin
            step();
            if (issue_ack_out != '0) begin
                check("crit_order", 64'(grant_id_out), 64'(exp_crit[n]));
                req_valid = req_valid & ~issue_ack_out;
                n++;
            end
        end
        check("crit_grants", 64'(n), 64'd4);

        // Hold under backpressure while inputs churn
        reset_dut();
        issue_ack_in = 1'b0;
        req_crit     = '0;
        req_valid    = 4'b0010;
        held         = pkt[1];
        step();
        check("bp_gid0", 64'(grant_id_out), 64'd1);
        for (int c = 0; c < 10; c++) begin
            randomize_inputs();
            step();
            check("bp_pkt", 64'(request_out), 64'(held));
            check("bp_gid", 64'(grant_id_out), 64'd1);
            check("bp_ack", 64'(issue_ack_out), 64'd0);
        end

        // Reset while holding: packet dropped, same requester re-granted
        reset_dut();
        check("midrst_vld", 64'(request_valid_out), 64'd0);
        check("midrst_pkt", 64'(request_out), 64'd0);
        check("midrst_ack", 64'(issue_ack_out), 64'd0);
        req_valid = 4'b0010;
        req_crit  = '0;
        pkt[1]    = held;
        step();
        check("regrant_gid", 64'(grant_id_out), 64'd1);
        check("regrant_pkt", 64'(request_out), 64'(held));
        check("regrant_ack", 64'(issue_ack_out), 64'b0010);
        issue_ack_in = 1'b1;
        step();

`ifdef TO_MEM_SCHEDULER_AGING_EN
        // Non-critical requester 1 competing against an always-critical requester 0
        begin
            bit got1;
            int edge_at;
            reset_dut();
            req_valid    = 4'b0011;
            req_crit     = 4'b0001;
            issue_ack_in = 1'b1;
            got1         = 1'b0;
            edge_at      = 0;
            for (int c = 1; c <= 60 && !got1; c++) begin
                step();
                if (issue_ack_out[1]) begin
                    got1    = 1'b1;
                    edge_at = c;
                end
            end
            check("age_granted", 64'(got1), 64'd1);
            check("age_edge", 64'(edge_at), 64'(AGE_T + 1));
        end
`endif

        // Random traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            randomize_inputs();
            issue_ack_in = $urandom_range(0, 1) == 1;
            reset_in     = $urandom_range(0, 99) == 0;
            step();
        end
        reset_in = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
